// File: rtl/kalman_pkg.sv
// Shared widths and FSM encoding for the kalman job scheduler.
package kalman_pkg;
   localparam int X_W    = 192;
   localparam int P_W    = 1152;
   localparam int Z_W    = 128;
   localparam int ELEM_W = 32;
   localparam int FRAC_W = 12;

   typedef enum logic [2:0] {
      S_EMPTY = 3'd0,
      S_READY = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;
endpackage

// File: rtl/kalman_meas_fifo.sv
// Synchronous measurement FIFO with one-cycle flush and occupancy count.
module kalman_meas_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 128,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop_ok, push_ok;

   // A pop frees the slot the same-cycle push lands in, so full+push+pop is legal.
   assign pop_ok  = pop & (count != '0);
   assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/kalman_sched.sv
// Job controller for the kalman core: holds x/P, queues z frames, sequences core runs.
// Optional core watchdog enabled by defining KALMAN_SCHED_TIMEOUT_EN.
module kalman_sched
   import kalman_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_valid,
   output logic             init_ready,
   input  logic [X_W-1:0]   init_x,
   input  logic [P_W-1:0]   init_P,
   input  logic             z_valid,
   output logic             z_ready,
   input  logic [Z_W-1:0]   z_data,
   input  logic             flush,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [X_W-1:0]   res_x,
   output logic [P_W-1:0]   res_P,
   output logic [CNT_W-1:0] res_iter,
   output logic             core_rst,
   output logic             core_start,
   output logic [X_W-1:0]   core_x,
   output logic [P_W-1:0]   core_P,
   output logic [Z_W-1:0]   core_z,
   input  logic             core_done,
   input  logic [X_W-1:0]   core_x_out,
   input  logic [P_W-1:0]   core_P_out,
   output logic             busy,
   output logic             err_timeout
);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("kalman_sched: FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
      $error("kalman_sched: TIMEOUT_CYCLES must be >= 1");
   end

   state_t           state, state_nxt;
   logic [X_W-1:0]   x_r;
   logic [P_W-1:0]   p_r;
   logic [Z_W-1:0]   z_hold;
   logic [CNT_W-1:0] iter;
   logic [Z_W-1:0]   f_dout;
   logic [FCW-1:0]   f_count;
   logic             init_fire, pop, tmo_hit;

   assign z_ready   = (f_count != FCW'(FIFO_DEPTH));
   assign init_fire = init_valid & init_ready;
   // Flush wins over a same-cycle pop so a discarded frame never starts a run.
   assign pop       = (state == S_READY) & ~init_valid & (f_count != '0) & ~flush;

   kalman_meas_fifo #(.DEPTH(FIFO_DEPTH), .W(Z_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (z_valid & z_ready),
      .pop   (pop),
      .flush (flush),
      .din   (z_data),
      .dout  (f_dout),
      .count (f_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      init_ready = 1'b0;
      core_start = 1'b0;
      busy       = 1'b0;
      res_valid  = 1'b0;
      case (state)
         S_EMPTY: begin
            init_ready = 1'b1;
            if (init_valid) state_nxt = S_READY;
         end
         S_READY: begin
            init_ready = 1'b1;
            if (pop) state_nxt = S_START;
         end
         S_START: begin
            core_start = 1'b1;
            busy       = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (core_done)    state_nxt = S_OUT;
            else if (tmo_hit) state_nxt = S_READY;
         end
         S_OUT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_READY;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r    <= '0;
         p_r    <= '0;
         z_hold <= '0;
         iter   <= '0;
      end else begin
         if (init_fire) begin
            x_r  <= init_x;
            p_r  <= init_P;
            iter <= '0;
         end else if (state == S_WAIT && core_done) begin
            x_r  <= core_x_out;
            p_r  <= core_P_out;
            iter <= iter + 1'b1;
         end
         if (pop) z_hold <= f_dout;
      end
   end

   assign core_x   = x_r;
   assign core_P   = p_r;
   assign core_z   = z_hold;
   assign res_x    = x_r;
   assign res_P    = p_r;
   assign res_iter = iter;

`ifdef KALMAN_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_rst, err_r;

   // Counter is zero on entry to S_WAIT; hit on the TIMEOUT_CYCLES-th wait cycle.
   assign tmo_hit = (state == S_WAIT) & ~core_done & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         tmo_rst <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         tmo_cnt <= (state == S_WAIT && !core_done && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
         tmo_rst <= tmo_hit;
         if (tmo_hit) err_r <= 1'b1;
      end
   end

   assign core_rst    = ~rst_n | tmo_rst;
   assign err_timeout = err_r;
`else
   assign tmo_hit     = 1'b0;
   assign core_rst    = ~rst_n;
   assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_kalman_sched.sv
// Scoreboard bench for kalman_sched with a stub core and a sequential reference model.
module tb_kalman_sched;
   import kalman_pkg::*;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            init_valid = 1'b0, init_ready;
   logic [X_W-1:0]  init_x = '0;
   logic [P_W-1:0]  init_P = '0;
   logic            z_valid = 1'b0, z_ready;
   logic [Z_W-1:0]  z_data = '0;
   logic            flush = 1'b0;
   logic            res_valid, res_ready = 1'b1;
   logic [X_W-1:0]  res_x;
   logic [P_W-1:0]  res_P;
   logic [15:0]     res_iter;
   logic            core_rst, core_start, core_done = 1'b0, busy, err_timeout;
   logic [X_W-1:0]  core_x, core_x_out;
   logic [P_W-1:0]  core_P, core_P_out;
   logic [Z_W-1:0]  core_z;

   always #5 clk = ~clk;

   kalman_sched #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .init_ready(init_ready),
      .init_x(init_x), .init_P(init_P), .z_valid(z_valid), .z_ready(z_ready),
      .z_data(z_data), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
      .res_x(res_x), .res_P(res_P), .res_iter(res_iter), .core_rst(core_rst),
      .core_start(core_start), .core_x(core_x), .core_P(core_P), .core_z(core_z),
      .core_done(core_done), .core_x_out(core_x_out), .core_P_out(core_P_out),
      .busy(busy), .err_timeout(err_timeout)
   );

   typedef struct { logic [X_W-1:0] x; logic [P_W-1:0] p; logic [15:0] it; } exp_t;
   exp_t           expq[$];
   logic [Z_W-1:0] zq[$];
   logic [X_W-1:0] mx;
   logic [P_W-1:0] mp;
   logic [15:0]    mi;
   int  errors = 0, checks = 0, n_starts = 0, done_lat = 5;
   bit  stall = 0, rnd_lat = 0, rr_rand = 0, rr_val = 1;

   // Arbitrary but deterministic "filter update" used by both the stub core and the model.
   function automatic logic [X_W-1:0] fx(input logic [X_W-1:0] x, input logic [Z_W-1:0] z);
      logic [X_W-1:0] r;
      for (int i = 0; i < 6; i++) r[i*32 +: 32] = x[i*32 +: 32] + z[(i%4)*32 +: 32] + 32'(i+1);
      return r;
   endfunction
   function automatic logic [P_W-1:0] fp(input logic [P_W-1:0] p, input logic [Z_W-1:0] z);
      logic [P_W-1:0] r;
      for (int j = 0; j < 36; j++) r[j*32 +: 32] = (p[j*32 +: 32] ^ z[(j%4)*32 +: 32]) + 32'd7;
      return r;
   endfunction
   function automatic logic [63:0] fold(input logic [P_W-1:0] v);
      logic [63:0] r = '0;
      for (int i = 0; i < 18; i++) r ^= v[i*64 +: 64];
      return r;
   endfunction

   assign core_x_out = fx(core_x, core_z);
   assign core_P_out = fp(core_P, core_z);

   task automatic chk(input string nm, input logic [X_W-1:0] got, input logic [X_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask
   task automatic chkp(input string nm, input logic [P_W-1:0] got, input logic [P_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got_fold=%h exp_fold=%h", nm, fold(got), fold(exp));
      end
   endtask

   // Stub core: done pulse a programmable number of cycles after start, dropped on core_rst.
   always begin : stub
      bit st, pend;
      int cnt;
      @(negedge clk);
      st = core_start;
      @(posedge clk); #1;
      core_done = 1'b0;
      if (!rst_n || core_rst) pend = 0;
      else if (st) begin
         pend = 1;
         cnt  = rnd_lat ? int'($urandom_range(1, 6)) : done_lat;
      end else if (pend && !stall) begin
         if (cnt <= 1) begin core_done = 1'b1; pend = 0; end
         else cnt--;
      end
   end

   always begin : rr_drv
      @(posedge clk); #1;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
   end

   // Monitor: start order/width, done->valid latency, result handshakes vs scoreboard.
   always begin : mon
      bit prev_start, prev_dw;
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         prev_start = 0; prev_dw = 0;
      end else begin
         if (core_start) begin
            n_starts++;
            if (prev_start) chk("start_width", 2, 1);
            if (zq.size() == 0) chk("unexpected_start", 1, 0);
            else chk("start_z", core_z, zq.pop_front());
         end
         if (prev_dw) chk("done_to_valid", res_valid, 1);
         if (res_valid && res_ready) begin
            if (expq.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               e = expq.pop_front();
               chk("res_x", res_x, e.x);
               chkp("res_P", res_P, e.p);
               chk("res_iter", res_iter, e.it);
            end
         end
         prev_start = core_start;
         prev_dw    = core_done & busy;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // mode 0: not recorded (to be flushed), 1: expect a start only, 2: start and result.
   task automatic model_push(input logic [Z_W-1:0] z, input int mode);
      if (mode >= 1) zq.push_back(z);
      if (mode == 2) begin
         mx = fx(mx, z); mp = fp(mp, z); mi = mi + 16'd1;
         expq.push_back('{x: mx, p: mp, it: mi});
      end
   endtask

   task automatic push_z(input logic [Z_W-1:0] z, input int mode, output bit acc);
      z_data = z; z_valid = 1'b1;
      @(negedge clk);
      acc = z_ready;
      tick();
      z_valid = 1'b0;
      if (acc) model_push(z, mode);
   endtask

   task automatic do_init(input logic [X_W-1:0] x, input logic [P_W-1:0] p);
      init_x = x; init_P = p; init_valid = 1'b1;
      @(negedge clk);
      chk("init_ready", init_ready, 1);
      tick();
      init_valid = 1'b0;
      mx = x; mp = p; mi = '0;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((expq.size() != 0 || zq.size() != 0) && n < bound) begin tick(); n++; end
      chk("drain", n < bound, 1);
      tick();
   endtask

   task automatic wait_start(input int bound);
      int n = 0;
      @(negedge clk);
      while (!core_start && n < bound) begin @(negedge clk); n++; end
      chk("start_seen", core_start, 1);
      tick();
   endtask

   function automatic logic [Z_W-1:0] rz();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   function automatic logic [P_W-1:0] rp();
      logic [P_W-1:0] r;
      for (int i = 0; i < 36; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin : main
      logic [P_W-1:0] pid;
      logic [Z_W-1:0] z;
      bit acc;
      int s0, n;

      // Reset state
      #2;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_iter", res_iter, 0);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_z_ready", z_ready, 1);
      chk("rst_core_x", core_x, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("core_rst_release", core_rst, 0);

      // Single frame: start latency and first result
      pid = '0;
      for (int i = 0; i < 6; i++) pid[(i*7)*32 +: 32] = 32'h1000;
      do_init('0, pid);
      done_lat = 10;
      z = rz(); z_data = z; z_valid = 1'b1;
      tick();
      z_valid = 1'b0;
      model_push(z, 2);
      @(negedge clk); chk("start_lat_t1", core_start, 0);
      @(negedge clk); chk("start_lat_t2", core_start, 1);
      @(negedge clk); chk("start_lat_t3", core_start, 0);
      tick();
      wait_drain(100);

      // Back-to-back frames, fast core, consumer always ready
      done_lat = 5;
      for (int k = 0; k < 4; k++) begin
         push_z(rz(), 2, acc);
         chk("z_ready_b2b", acc, 1);
      end
      wait_drain(200);

      // Fill while stalled, reject when full, flush; running job still completes
      stall = 1;
      push_z(rz(), 2, acc);
      wait_start(20);
      for (int k = 0; k < 4; k++) begin
         push_z(rz(), 0, acc);
         chk("z_ready_fill", acc, 1);
      end
      push_z(rz(), 0, acc);
      chk("z_full_reject", acc, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_empty", z_ready, 1);
      stall = 0;
      tick();
      wait_drain(100);
      s0 = n_starts;
      repeat (15) tick();
      chk("no_start_after_flush", n_starts, s0);

      // Back-pressure: result held, no new start, init blocked
      rr_val = 0;
      push_z(rz(), 2, acc);
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 50) begin @(negedge clk); n++; end
      chk("hold_valid_seen", res_valid, 1);
      tick();
      push_z(rz(), 2, acc);
      repeat (20) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_x", res_x, expq[0].x);
         chk("hold_iter", res_iter, expq[0].it);
         chk("hold_init_ready", init_ready, 0);
         chk("hold_no_start", core_start, 0);
      end
      rr_val = 1;
      tick();
      wait_drain(100);
      @(negedge clk);
      chk("ready_after_release", init_ready, 1);
      tick();

      // Randomized streaming with random core latency and consumer stalls
      rr_rand = 1; rnd_lat = 1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) != 0) push_z(rz(), 2, acc);
            else tick();
         end
         wait_drain(2000);
         rr_rand = 0;
         repeat (3) tick();
         do_init({rz(), rz()}, rp());
         rr_rand = 1;
      end
      rr_rand = 0; rnd_lat = 0;
      repeat (3) tick();

`ifdef KALMAN_SCHED_TIMEOUT_EN
      // Watchdog: stalled core is reset, frame dropped, next frame runs
      stall = 1;
      push_z(rz(), 1, acc);
      push_z(rz(), 2, acc);
      n = 0;
      while (!core_start && n < 20) begin @(negedge clk); n++; end
      n = 0;
      do begin @(negedge clk); n++; end while (!core_rst && n < 40);
      chk("tmo_len", n, 17);
      chk("tmo_err", err_timeout, 1);
      stall = 0;
      tick();
      wait_drain(100);
`endif

      // Asynchronous reset during a core run
      stall = 1;
      push_z(rz(), 2, acc);
      wait_start(20);
      push_z(rz(), 0, acc);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_start", core_start, 0);
      chk("mid_rst_core_rst", core_rst, 1);
      chk("mid_rst_iter", res_iter, 0);
      chk("mid_rst_core_x", core_x, 0);
      chk("mid_rst_core_z", core_z, 0);
      chk("mid_rst_z_ready", z_ready, 1);
      chk("mid_rst_err", err_timeout, 0);
      zq.delete(); expq.delete();
      stall = 0;
      tick();
      rst_n = 1'b1;
      tick();
      s0 = n_starts;
      do_init('0, pid);
      repeat (10) tick();
      chk("rst_fifo_empty", n_starts, s0);
      @(negedge clk);
      chk("rst_ready", init_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
